// File: rtl/axis_usb_arb.sv
// Arbiter between an AXI-Stream pair and a half-duplex FIFO-style USB bridge
// (FT-style TXE#/RXF#/RD#/WR#/OE#/SIWU# interface) sharing one data bus.
module axis_usb_arb #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned PACKET_SIZE  = 510,
    parameter int unsigned IDLE_TIMEOUT = 31,
    parameter int unsigned TX_BURST     = 64,
    parameter int unsigned RX_BURST     = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  usb_full,
    input  logic                  usb_empty,
    output logic                  usb_rdn,
    output logic                  usb_wrn,
    output logic                  usb_oen,
    output logic                  usb_siwun,
    inout  wire  [DATA_WIDTH-1:0] usb_data,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [31:0]           tx_words,
    output logic [31:0]           rx_words
);

    localparam int unsigned PKT_W = $clog2(PACKET_SIZE + 1);
    localparam int unsigned TXB_W = $clog2(TX_BURST + 1);
    localparam int unsigned RXB_W = $clog2(RX_BURST + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StTx   = 2'd1;
    localparam logic [1:0] StTurn = 2'd2;
    localparam logic [1:0] StRx   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  last_tx_q, last_tx_d;
    logic [DATA_WIDTH-1:0] rx_buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            rx_cnt_q, rx_cnt_d;
    logic [PKT_W-1:0]      pkt_q, pkt_d;
    logic [7:0]            idle_q, idle_d;
    logic [TXB_W-1:0]      tx_burst_q, tx_burst_nxt;
    logic [RXB_W-1:0]      rx_burst_q, rx_burst_nxt;
    logic [31:0]           tx_words_q, rx_words_q;

    logic rx_pending, tx_pending;
    logic rd_en, wr_en, pop;
    logic tx_burst_hit, rx_burst_hit;
    logic siwu;

    assign rx_pending = ~usb_empty & (rx_cnt_q < 2'd2);
    assign tx_pending = s_axis_tvalid & ~usb_full;
    assign rd_en      = (state_q == StRx) & rx_pending;
    assign wr_en      = (state_q == StTx) & tx_pending;
    assign pop        = m_axis_tvalid & m_axis_tready;

    assign usb_rdn       = ~rd_en;
    assign usb_wrn       = ~wr_en;
    assign usb_oen       = ~((state_q == StTurn) | (state_q == StRx));
    assign s_axis_tready = wr_en;
    assign usb_data      = wr_en ? s_axis_tdata : {DATA_WIDTH{1'bz}};

    assign m_axis_tvalid = (rx_cnt_q != 2'd0);
    assign m_axis_tdata  = rx_buf_q[rd_ptr_q];
    assign tx_words      = tx_words_q;
    assign rx_words      = rx_words_q;

    // Burst counters saturate so a grant can run on once the limit is reached.
    assign tx_burst_nxt = (wr_en && tx_burst_q != TXB_W'(TX_BURST)) ?
                          tx_burst_q + TXB_W'(1) : tx_burst_q;
    assign rx_burst_nxt = (rd_en && rx_burst_q != RXB_W'(RX_BURST)) ?
                          rx_burst_q + RXB_W'(1) : rx_burst_q;
    assign tx_burst_hit = (tx_burst_nxt == TXB_W'(TX_BURST));
    assign rx_burst_hit = (rx_burst_nxt == RXB_W'(RX_BURST));

    assign siwu      = (idle_q == 8'(IDLE_TIMEOUT)) && (state_q != StTx);
    assign usb_siwun = ~siwu;

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        case ({rd_en, pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 2'd1;
            2'b01:   rx_cnt_d = rx_cnt_q - 2'd1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        last_tx_d = last_tx_q;
        case (state_q)
            StIdle: begin
                if (rx_pending && (last_tx_q || !tx_pending)) begin
                    state_d   = StTurn;
                    last_tx_d = 1'b0;
                end else if (tx_pending) begin
                    state_d   = StTx;
                    last_tx_d = 1'b1;
                end
            end
            StTx: begin
                if (!tx_pending || (tx_burst_hit && rx_pending)) state_d = StIdle;
            end
            StTurn: state_d = StRx;
            StRx: begin
                if (usb_empty || rx_cnt_d == 2'd2 || (rx_burst_hit && tx_pending)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pkt_d = pkt_q;
        if (siwu || usb_full) begin
            pkt_d = '0;
        end else if (wr_en) begin
            pkt_d = (pkt_q == PKT_W'(PACKET_SIZE - 1)) ? '0 : pkt_q + PKT_W'(1);
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (siwu || wr_en || pkt_q == '0) begin
            idle_d = 8'd0;
        end else if (!tx_pending && idle_q != 8'(IDLE_TIMEOUT)) begin
            idle_d = idle_q + 8'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            last_tx_q   <= 1'b0;
            rx_buf_q[0] <= '0;
            rx_buf_q[1] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            rx_cnt_q    <= 2'd0;
            pkt_q       <= '0;
            idle_q      <= 8'd0;
            tx_burst_q  <= '0;
            rx_burst_q  <= '0;
            tx_words_q  <= 32'd0;
            rx_words_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_tx_q <= last_tx_d;
            rx_cnt_q  <= rx_cnt_d;
            pkt_q     <= pkt_d;
            idle_q    <= idle_d;
            if (rd_en) begin
                rx_buf_q[wr_ptr_q] <= usb_data;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            // Every grant starts from IDLE, so that is where the bursts restart.
            tx_burst_q <= (state_q == StIdle) ? '0 : tx_burst_nxt;
            rx_burst_q <= (state_q == StIdle) ? '0 : rx_burst_nxt;
            tx_words_q <= tx_words_q + {31'd0, wr_en};
            rx_words_q <= rx_words_q + {31'd0, rd_en};
        end
    end

endmodule

// File: tb/tb_axis_usb_arb.sv
// Bench for axis_usb_arb: device and stream-source models feed queues, a
// negedge monitor scores bus writes and AXIS reads against expected queues.
module tb_axis_usb_arb;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       usb_full = 1'b0;
    logic       usb_empty = 1'b1;
    logic       usb_rdn, usb_wrn, usb_oen, usb_siwun;
    wire  [7:0] usb_data;
    logic [7:0] dev_data = 8'h00;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic [31:0] tx_words, rx_words;

    int total = 0;
    int bad = 0;

    logic [7:0] src_q[$];
    logic [7:0] dev_q[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    logic       tx_hs = 1'b0;
    logic       rd_now = 1'b0;
    logic       rd_prev = 1'b0;

    typedef struct {
        bit          is_rx;
        int          n;
        logic [7:0]  base;
        int unsigned exp_tx;
        int unsigned exp_rx;
    } txn_t;
    txn_t tbl[4];

    axis_usb_arb #(
        .DATA_WIDTH  (8),
        .PACKET_SIZE (510),
        .IDLE_TIMEOUT(31),
        .TX_BURST    (4),
        .RX_BURST    (4)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .usb_full     (usb_full),
        .usb_empty    (usb_empty),
        .usb_rdn      (usb_rdn),
        .usb_wrn      (usb_wrn),
        .usb_oen      (usb_oen),
        .usb_siwun    (usb_siwun),
        .usb_data     (usb_data),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .tx_words     (tx_words),
        .rx_words     (rx_words)
    );

    // The device drives the bus only while the arbiter holds OE# low.
    assign usb_data = usb_oen ? 8'hzz : dev_data;

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    always @(negedge aclk) begin
        if (!aresetn) begin
            tx_hs   = 1'b0;
            rd_now  = 1'b0;
            rd_prev = 1'b0;
        end else begin
            if (rd_prev) chk("rx_latency_tvalid", m_axis_tvalid, 1);
            if (!usb_wrn) begin
                chk("oen_during_write", usb_oen, 1);
                if (tx_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_extra: got write %0h, want none", usb_data);
                end else begin
                    chk("tx_data", usb_data, tx_exp.pop_front());
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (rx_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_extra: got word %0h, want none", m_axis_tdata);
                end else begin
                    chk("rx_data", m_axis_tdata, rx_exp.pop_front());
                end
            end
            tx_hs   = s_axis_tvalid && s_axis_tready;
            rd_now  = !usb_rdn && !usb_empty;
            rd_prev = rd_now;
        end
    end

    always @(posedge aclk) begin
        #1;
        if (tx_hs && src_q.size() != 0) void'(src_q.pop_front());
        s_axis_tvalid = (src_q.size() != 0);
        s_axis_tdata  = s_axis_tvalid ? src_q[0] : 8'h00;
    end

    always @(posedge aclk) begin
        #1;
        if (rd_now && dev_q.size() != 0) void'(dev_q.pop_front());
        usb_empty = (dev_q.size() == 0);
        dev_data  = usb_empty ? 8'h00 : dev_q[0];
    end

    task automatic run_txn(input txn_t t);
        int  cnt;
        bit  seen;
        @(negedge aclk);
        #1;
        for (int i = 0; i < t.n; i++) begin
            logic [7:0] b;
            b = t.base + 8'(i);
            if (t.is_rx) begin
                dev_q.push_back(b);
                rx_exp.push_back(b);
            end else begin
                src_q.push_back(b);
                tx_exp.push_back(b);
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            if (t.is_rx ? !usb_empty : s_axis_tvalid) seen = 1'b1;
        end
        if (!seen) begin
            tmo("txn_start");
            return;
        end
        // Work has just become visible: the arbiter is still in IDLE.
        chk("idle_oen", usb_oen, 1);
        chk(t.is_rx ? "idle_rdn" : "idle_wrn", t.is_rx ? usb_rdn : usb_wrn, 1);
        if (t.is_rx) begin
            @(negedge aclk);
            chk("turn_oen", usb_oen, 0);
            chk("turn_rdn", usb_rdn, 1);
        end
        cnt = 0;
        for (int i = 0; i < t.n; i++) begin
            @(negedge aclk);
            if ((t.is_rx ? usb_rdn : usb_wrn) == 1'b0) cnt++;
        end
        chk("strobe_run", cnt, t.n);
        @(negedge aclk);
        chk("strobe_end", t.is_rx ? usb_rdn : usb_wrn, 1);
        @(negedge aclk);
        chk("tx_words", tx_words, t.exp_tx);
        chk("rx_words", rx_words, t.exp_rx);
        settle(40);
    endtask

    task automatic backpressure_test();
        int cnt;
        bit done;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        @(negedge aclk);
        #1;
        dev_q.push_back(8'hB1); rx_exp.push_back(8'hB1);
        dev_q.push_back(8'hB2); rx_exp.push_back(8'hB2);
        dev_q.push_back(8'hB3); rx_exp.push_back(8'hB3);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            if (!usb_rdn) cnt++;
        end
        chk("bp_reads", cnt, 2);
        chk("bp_oen_released", usb_oen, 1);
        chk("bp_tvalid", m_axis_tvalid, 1);
        chk("bp_tdata_oldest", m_axis_tdata, 8'hB1);
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge aclk);
            if (rx_exp.size() == 0 && dev_q.size() == 0) done = 1'b1;
        end
        if (!done) tmo("bp_drain");
        chk("bp_rx_words", rx_words, 9);
        settle(40);
    endtask

    task automatic siwu_test();
        int  cnt;
        int  n;
        bit  found;
        int  lows;
        @(negedge aclk);
        #1;
        for (int i = 0; i < 5; i++) begin
            src_q.push_back(8'hC0 + 8'(i));
            tx_exp.push_back(8'hC0 + 8'(i));
        end
        cnt = 0;
        for (int i = 0; i < 30 && cnt < 5; i++) begin
            @(negedge aclk);
            if (!usb_wrn) cnt++;
        end
        if (cnt < 5) tmo("siwu_writes");
        // Write edge ends the cycle just sampled; the pulse starts 31 edges later.
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 60 && !found; i++) begin
            @(negedge aclk);
            if (!usb_siwun) begin
                found = 1'b1;
                n = i;
            end
        end
        chk("siwu_delay", n, 32);
        @(negedge aclk);
        chk("siwu_width", usb_siwun, 1);
        settle(5);
        @(negedge aclk);
        #1;
        for (int i = 0; i < 510; i++) begin
            src_q.push_back(8'(i));
            tx_exp.push_back(8'(i));
        end
        lows = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge aclk);
            if (!usb_siwun) lows++;
        end
        chk("siwu_full_packet", lows, 0);
        chk("pkt_tx_words", tx_words, 528);
        chk("pkt_tx_drained", tx_exp.size(), 0);
    endtask

    task automatic alt_test();
        int wr_runs[$];
        int rd_runs[$];
        int cur, len, gap, last_kind, kind, clash, odd_runs;
        cur = 0; len = 0; gap = 0; last_kind = 0; clash = 0; odd_runs = 0;
        @(negedge aclk);
        #1;
        for (int i = 0; i < 12; i++) begin
            src_q.push_back(8'h60 + 8'(i));
            tx_exp.push_back(8'h60 + 8'(i));
            dev_q.push_back(8'h90 + 8'(i));
            rx_exp.push_back(8'h90 + 8'(i));
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (!usb_oen && !usb_wrn) clash++;
            kind = !usb_wrn ? 1 : (!usb_rdn ? 2 : 0);
            if (kind != 0 && kind == cur) begin
                len++;
            end else begin
                if (cur != 0) begin
                    if (cur == 1) wr_runs.push_back(len);
                    else rd_runs.push_back(len);
                    last_kind = cur;
                    gap = 0;
                end
                if (kind != 0) begin
                    if (last_kind == 1 && kind == 2) chk("gap_wr_to_rd", gap, 2);
                    if (last_kind == 2 && kind == 1) chk("gap_rd_to_wr", gap, 1);
                    len = 1;
                    gap = 0;
                end else begin
                    gap++;
                end
                cur = kind;
            end
            if (kind == 0 && src_q.size() == 0 && dev_q.size() == 0 && rx_exp.size() == 0) break;
        end
        foreach (wr_runs[k]) if (wr_runs[k] != 4) odd_runs++;
        foreach (rd_runs[k]) if (rd_runs[k] != 4) odd_runs++;
        chk("alt_runs_not_4", odd_runs, 0);
        chk("alt_wr_runs", wr_runs.size(), 3);
        chk("alt_rd_runs", rd_runs.size(), 3);
        chk("alt_oen_wrn_clash", clash, 0);
        @(negedge aclk);
        chk("alt_tx_words", tx_words, 540);
        chk("alt_rx_words", rx_words, 21);
        settle(40);
    endtask

    task automatic reset_mid_rx_test();
        bit seen;
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        @(negedge aclk);
        #1;
        dev_q.push_back(8'hD1);
        dev_q.push_back(8'hD2);
        dev_q.push_back(8'hD3);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid) seen = 1'b1;
        end
        if (!seen) begin
            tmo("rst_wait_buffered");
            return;
        end
        chk("rst_pre_rdn", usb_rdn, 0);
        aresetn = 1'b0;
        #1;
        chk("rst_async_rdn", usb_rdn, 1);
        chk("rst_async_wrn", usb_wrn, 1);
        chk("rst_async_oen", usb_oen, 1);
        chk("rst_async_siwun", usb_siwun, 1);
        chk("rst_async_tvalid", m_axis_tvalid, 0);
        repeat (2) @(posedge aclk);
        #2;
        dev_q.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        settle(3);
        chk("rst_post_tvalid", m_axis_tvalid, 0);
        chk("rst_post_rx_words", rx_words, 0);
        chk("rst_post_tx_words", tx_words, 0);
        chk("rst_post_rdn", usb_rdn, 1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 10, 8'h10, 10, 0};
        tbl[1] = '{1'b1, 4, 8'hA1, 10, 4};
        tbl[2] = '{1'b0, 3, 8'h55, 13, 4};
        tbl[3] = '{1'b1, 2, 8'hF0, 13, 6};

        settle(3);
        chk("reset_rdn", usb_rdn, 1);
        chk("reset_wrn", usb_wrn, 1);
        chk("reset_oen", usb_oen, 1);
        chk("reset_siwun", usb_siwun, 1);
        chk("reset_tready", s_axis_tready, 0);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tx_words", tx_words, 0);
        chk("reset_rx_words", rx_words, 0);
        aresetn = 1'b1;
        settle(3);

        for (int i = 0; i < 4; i++) run_txn(tbl[i]);
        backpressure_test();
        siwu_test();
        alt_test();
        chk("tx_queue_empty", tx_exp.size(), 0);
        chk("rx_queue_empty", rx_exp.size(), 0);
        reset_mid_rx_test();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
